// File: rtl/bus_sequencer.sv
// PlayBus sequencer: expands a latched function code into break-before-make
// source enables and sink strobes, including an 8-word ROM-to-RAM block copy.
module bus_sequencer #(
    parameter int XFER_MAX = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [2:0] func,
    input  logic [2:0] address,
    input  logic       contend,
    output logic       n_SWBEN,
    output logic       n_ROMO,
    output logic       n_RAMO,
    output logic       n_RAMW,
    output logic       LEDLTCH,
    output logic [2:0] addr_out,
    output logic       addr_sel,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TURN    = 3'd1,
        S_DRIVE   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [2:0] LAST_WORD = 3'(XFER_MAX - 1);

    state_t     state_q, state_d;
    logic [2:0] func_q, func_d;
    logic [2:0] addr_q, addr_d;
    logic       err_q, err_d;
    logic       n_swben_q, n_swben_d;
    logic       n_romo_q, n_romo_d;
    logic       n_ramo_q, n_ramo_d;
    logic       n_ramw_q, n_ramw_d;
    logic       ledltch_q, ledltch_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       addr_sel_q, addr_sel_d;
    logic       src_on_s;

    // Next state, then outputs decoded from the next state so they are registered with it.
    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        addr_d  = addr_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    func_d  = func;
                    addr_d  = (func == 3'd6) ? 3'd0 : address;
                    err_d   = (func == 3'd7);
                    state_d = ((func == 3'd0) || (func == 3'd7)) ? S_DONE : S_TURN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TURN: state_d = S_DRIVE;
            S_DRIVE: begin
                if (contend) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (contend) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (func_q == 3'd6) begin
                    addr_d  = addr_q + 3'd1;
                    state_d = (addr_q == LAST_WORD) ? S_DONE : S_TURN;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        src_on_s   = (state_d == S_DRIVE) || (state_d == S_CAPTURE);
        n_swben_d  = 1'b1;
        n_romo_d   = 1'b1;
        n_ramo_d   = 1'b1;
        n_ramw_d   = 1'b1;
        ledltch_d  = 1'b0;
        addr_sel_d = 1'b0;
        unique case (func_d)
            3'd1, 3'd4: n_swben_d = ~src_on_s;
            3'd2, 3'd5, 3'd6: n_romo_d = ~src_on_s;
            3'd3: n_ramo_d = ~src_on_s;
            default: n_swben_d = 1'b1;
        endcase
        if (state_d == S_CAPTURE) begin
            ledltch_d = (func_d == 3'd1) || (func_d == 3'd2) || (func_d == 3'd3);
            n_ramw_d  = ~((func_d == 3'd4) || (func_d == 3'd5) || (func_d == 3'd6));
        end else begin
            ledltch_d = 1'b0;
            n_ramw_d  = 1'b1;
        end
        if ((state_d == S_TURN) || src_on_s) begin
            addr_sel_d = (func_d >= 3'd2) && (func_d <= 3'd6);
        end else begin
            addr_sel_d = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // FSM state and all registered outputs; reset forces every enable inactive at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            func_q     <= 3'd0;
            addr_q     <= 3'd0;
            err_q      <= 1'b0;
            n_swben_q  <= 1'b1;
            n_romo_q   <= 1'b1;
            n_ramo_q   <= 1'b1;
            n_ramw_q   <= 1'b1;
            ledltch_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            func_q     <= func_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            n_swben_q  <= n_swben_d;
            n_romo_q   <= n_romo_d;
            n_ramo_q   <= n_ramo_d;
            n_ramw_q   <= n_ramw_d;
            ledltch_q  <= ledltch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            addr_sel_q <= addr_sel_d;
        end
    end

    assign n_SWBEN  = n_swben_q;
    assign n_ROMO   = n_romo_q;
    assign n_RAMO   = n_ramo_q;
    assign n_RAMW   = n_ramw_q;
    assign LEDLTCH  = ledltch_q;
    assign addr_out = addr_q;
    assign addr_sel = addr_sel_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer with a small switch/ROM/RAM/LED bus model.
module tb_bus_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       go = 1'b0;
    logic [2:0] func = 3'd0;
    logic [2:0] address = 3'd0;
    logic       contend = 1'b0;
    logic       n_SWBEN, n_ROMO, n_RAMO, n_RAMW, LEDLTCH;
    logic [2:0] addr_out;
    logic       addr_sel, busy, done, err;

    bus_sequencer #(.XFER_MAX(8)) dut (
        .clk(clk), .reset(reset), .go(go), .func(func), .address(address),
        .contend(contend), .n_SWBEN(n_SWBEN), .n_ROMO(n_ROMO), .n_RAMO(n_RAMO),
        .n_RAMW(n_RAMW), .LEDLTCH(LEDLTCH), .addr_out(addr_out),
        .addr_sel(addr_sel), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Peripheral model: switch buffer, ROM, RAM and LED latch on a shared bus.
    logic [3:0] sw = 4'hA;
    logic [3:0] led = 4'h0;
    logic [3:0] rom [8];
    logic [3:0] ram [8];
    logic [3:0] bus_s;
    logic [2:0] eff_addr_s;

    assign eff_addr_s = addr_sel ? addr_out : address;
    always_comb begin
        if (!n_SWBEN)     bus_s = sw;
        else if (!n_ROMO) bus_s = rom[eff_addr_s];
        else if (!n_RAMO) bus_s = ram[eff_addr_s];
        else              bus_s = 4'h0;
    end
    always @(posedge clk) begin
        if (LEDLTCH) led <= bus_s;
        if (!n_RAMW) ram[eff_addr_s] <= bus_s;
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] tr_ctl  [0:40];
    logic [2:0] tr_addr [0:40];
    logic       tr_sel  [0:40];

    function automatic logic [7:0] ctl_now();
        return {n_SWBEN, n_ROMO, n_RAMO, n_RAMW, LEDLTCH, busy, done, err};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start one operation (edge 0 samples go) and record cycles 1..ncyc at the falling edge.
    task automatic run(input logic [2:0] f, input logic [2:0] a, input int ncyc,
                       input int cont_cyc, input int gp_cyc);
        @(negedge clk);
        func = f; address = a; go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            tr_ctl[c]  = ctl_now();
            tr_addr[c] = addr_out;
            tr_sel[c]  = addr_sel;
            contend = (c == cont_cyc);
            go      = (c == gp_cyc);
            if (c == gp_cyc) func = 3'd1;
        end
        contend = 1'b0;
        go = 1'b0;
    endtask

    logic [7:0] exp_ctl [1:5];
    logic [7:0] blk_pat [3];
    int cnt_done, cnt_ramw, cnt_led;

    initial begin
        rom = '{4'h3, 4'h9, 4'hC, 4'h6, 4'h1, 4'hE, 4'h5, 4'h7};
        for (int i = 0; i < 8; i++) ram[i] = 4'h0;
        blk_pat = '{8'hF4, 8'hB4, 8'hA4};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_ctl", 32'(ctl_now()), 32'h0F0);
        chk("reset_addr", 32'(addr_out), 32'h0);
        chk("reset_sel", 32'(addr_sel), 32'h0);

        // SW -> LED
        run(3'd1, 3'd0, 5, 0, 0);
        exp_ctl = '{8'hF4, 8'h74, 8'h7C, 8'hF6, 8'hF0};
        for (int c = 1; c <= 5; c++) chk($sformatf("sw_led_c%0d", c), 32'(tr_ctl[c]), 32'(exp_ctl[c]));
        chk("sw_led_value", 32'(led), 32'hA);

        // ROM[3] -> RAM[3]
        run(3'd5, 3'd3, 5, 0, 0);
        exp_ctl = '{8'hF4, 8'hB4, 8'hA4, 8'hF6, 8'hF0};
        for (int c = 1; c <= 5; c++) chk($sformatf("rom_ram_c%0d", c), 32'(tr_ctl[c]), 32'(exp_ctl[c]));
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("rom_ram_addr_c%0d", c), 32'(tr_addr[c]), 32'h3);
            chk($sformatf("rom_ram_sel_c%0d", c), 32'(tr_sel[c]), 32'h1);
        end
        chk("rom_ram_sel_done", 32'(tr_sel[4]), 32'h0);
        chk("rom_ram_mem", 32'(ram[3]), 32'h6);

        // RAM[3] -> LED reads back the copied ROM word
        run(3'd3, 3'd3, 5, 0, 0);
        exp_ctl = '{8'hF4, 8'hD4, 8'hDC, 8'hF6, 8'hF0};
        for (int c = 1; c <= 5; c++) chk($sformatf("ram_led_c%0d", c), 32'(tr_ctl[c]), 32'(exp_ctl[c]));
        chk("ram_led_value", 32'(led), 32'h6);

        // Block copy: TURN/DRIVE/CAPTURE per word, DONE in cycle 25
        run(3'd6, 3'd5, 26, 0, 0);
        for (int c = 1; c <= 24; c++) begin
            chk($sformatf("blk_ctl_c%0d", c), 32'(tr_ctl[c]), 32'(blk_pat[(c - 1) % 3]));
            chk($sformatf("blk_addr_c%0d", c), 32'(tr_addr[c]), 32'((c - 1) / 3));
            chk($sformatf("blk_sel_c%0d", c), 32'(tr_sel[c]), 32'h1);
        end
        chk("blk_done_c25", 32'(tr_ctl[25]), 32'h0F6);
        chk("blk_sel_c25", 32'(tr_sel[25]), 32'h0);
        chk("blk_idle_c26", 32'(tr_ctl[26]), 32'h0F0);
        for (int i = 0; i < 8; i++) chk($sformatf("blk_ram%0d", i), 32'(ram[i]), 32'(rom[i]));

        // SW -> RAM[5] aborted by contention in DRIVE
        run(3'd4, 3'd5, 4, 2, 0);
        exp_ctl = '{8'hF4, 8'h74, 8'hF7, 8'hF1, 8'hF1};
        for (int c = 1; c <= 4; c++) chk($sformatf("abort_c%0d", c), 32'(tr_ctl[c]), 32'(exp_ctl[c]));
        chk("abort_ram_kept", 32'(ram[5]), 32'hE);

        // NOP clears the sticky error
        run(3'd0, 3'd0, 2, 0, 0);
        chk("nop_c1", 32'(tr_ctl[1]), 32'h0F6);
        chk("nop_c2", 32'(tr_ctl[2]), 32'h0F0);

        // Illegal code
        run(3'd7, 3'd0, 2, 0, 0);
        chk("illegal_c1", 32'(tr_ctl[1]), 32'h0F7);
        chk("illegal_c2", 32'(tr_ctl[2]), 32'h0F1);

        // go pulse during a block copy is ignored
        run(3'd6, 3'd0, 30, 0, 5);
        cnt_done = 0; cnt_ramw = 0; cnt_led = 0;
        for (int c = 1; c <= 30; c++) begin
            cnt_done += int'(tr_ctl[c][1]);
            cnt_ramw += int'(!tr_ctl[c][4]);
            cnt_led  += int'(tr_ctl[c][3]);
        end
        chk("ignore_done_cnt", 32'(cnt_done), 32'd1);
        chk("ignore_ramw_cnt", 32'(cnt_ramw), 32'd8);
        chk("ignore_led_cnt", 32'(cnt_led), 32'd0);
        chk("ignore_done_c25", 32'(tr_ctl[25]), 32'h0F6);

        // Reset asserted in cycle 10 of a block copy
        run(3'd6, 3'd0, 10, 0, 0);
        chk("rst_mid_busy", 32'(tr_ctl[10][2]), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_ctl", 32'(ctl_now()), 32'h0F0);
        chk("rst_mid_addr", 32'(addr_out), 32'h0);
        chk("rst_mid_sel", 32'(addr_sel), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_idle", 32'(ctl_now()), 32'h0F0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bus_sequencer.md
# bus_sequencer

Multi-cycle sequencer for the PlayBus 4-bit shared data bus. It turns a latched function code into a safe sequence of tri-state driver enables and sink strobes for the switch buffer, EPROM, RAM and LED latch. Every transfer has a break-before-make turnaround cycle, and any bus contention aborts the transfer. It sits between the function/address latches and the bus peripherals, and adds an 8-word block-copy mode that drives its own address.

## Interface
Parameters:
- `XFER_MAX`, default 8: number of words in a block operation; the address counter width is 3.

Ports:
- `clk` (in, 1): system clock; all state changes on the rising edge.
- `reset` (in, 1): asynchronous, active-high; clears all state immediately.
- `go` (in, 1): start request; sampled only in IDLE.
- `func` (in, 3): function code, captured when `go` is accepted.
- `address` (in, 3): user address, captured when `go` is accepted.
- `contend` (in, 1): bus contention flag from the contention detector.
- `n_SWBEN`, `n_ROMO`, `n_RAMO` (out, 1 each): active-low bus source enables.
- `n_RAMW` (out, 1): active-low RAM write strobe.
- `LEDLTCH` (out, 1): active-high LED register load.
- `addr_out` (out, 3): address presented to ROM/RAM.
- `addr_sel` (out, 1): 1 selects `addr_out` over the user address latch.
- `busy` (out, 1), `done` (out, 1), `err` (out, 1): status outputs.

## Operation
Function codes:
- 0 (NOP): no bus activity; `done` only.
- 1: SW→LED.
- 2: ROM[a]→LED.
- 3: RAM[a]→LED.
- 4: SW→RAM[a].
- 5: ROM[a]→RAM[a].
- 6: block copy ROM[0..7]→RAM[0..7].
- 7: illegal; sets `err`, then `done`; no bus activity.

States:
- IDLE: `busy`=0. When `go`=1, capture `func` and `address`, clear `err`, then go to TURN. Codes 0 and 7 go directly to DONE.
- TURN: all sources and sinks inactive for one cycle (break-before-make).
- DRIVE: the selected source enable is low and the sink is inactive; data settles.
- CAPTURE: the source stays enabled. The sink strobe is active for exactly one cycle: `LEDLTCH`=1, or `n_RAMW`=0.
- After CAPTURE:
  - Single-word functions go to DONE.
  - Code 6 increments `addr_out`. If the word index is below 7 it returns to TURN; otherwise it goes to DONE.
- DONE: `done`=1 for one cycle with all enables inactive, then IDLE.
- ABORT: if `contend`=1 in DRIVE or CAPTURE:
  - All enables and strobes go inactive on the next edge, including any strobe scheduled for that edge.
  - `err` is set and the state goes to DONE.
  - The block copy does not continue.

Address handling:
- For codes 2–5, `addr_out` = captured address and `addr_sel`=1 from TURN through CAPTURE.
- For code 6, `addr_out` starts at 0 and `addr_sel`=1 throughout.
- `addr_sel`=0 in IDLE and DONE.

Invariants:
- At most one of `n_SWBEN`, `n_ROMO`, `n_RAMO` is low at any time.
- `n_RAMO` and `n_RAMW` are never low together.
- A source enable never changes in the same cycle a strobe is active.

Other rules:
- `err` is sticky until the next accepted `go`.
- `go` is ignored while `busy`=1.

## Timing
Reset values:
- `n_SWBEN`, `n_ROMO`, `n_RAMO`, `n_RAMW` = 1.
- `LEDLTCH`, `busy`, `done`, `err`, `addr_sel` = 0.
- `addr_out` = 0.
- State = IDLE.

Cycle timing (edge 0 is the edge that samples `go`=1):
- `busy` rises after edge 0 and falls after the DONE cycle.
- Single transfer: TURN, DRIVE, CAPTURE, DONE. `done` is high in cycle 4 and the block is back in IDLE from cycle 5.
- NOP and illegal codes: `done` in cycle 1.
- Block copy: 8×3 transfer cycles, then DONE in cycle 25.
- `go` held high continuously starts a new operation on the first edge after returning to IDLE.

Reset mid-operation:
- All outputs return immediately to their reset values (asynchronous).
- No partial strobe may extend beyond reset assertion.

## Test plan
- After reset, `func`=1, `sw0`=4'hA, pulse `go` → `n_SWBEN` low in cycles 2–3, `LEDLTCH`=1 in cycle 3 only, LED shows A, `done` in cycle 4, `err`=0.
- `func`=5, `address`=3 → `n_ROMO` low in cycles 2–3, `n_RAMW`=0 in cycle 3, `addr_out`=3; a later `func`=3 read returns ROM[3].
- `func`=6 → 8 write strobes with `addr_out` stepping 0..7, `done` in cycle 25, RAM[i]=ROM[i] for all i; `n_RAMO` stays 1 throughout.
- `func`=4 with `contend` forced to 1 in DRIVE → no `n_RAMW` pulse, all enables high next cycle, `err`=1, `done` pulse; the next `go` with `func`=0 clears `err`.
- `func`=7 → `done` in cycle 1 with `err`=1 and no enable activity. A `go` pulse during a block copy is ignored: the copy completes, and exactly one operation occurs.
- Assert `reset` in cycle 10 of a block copy → outputs return to reset values immediately, `busy`=0, and the state is IDLE.
